// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size codes, LSU states and the
// major opcodes the decoder uses to raise mem_rd/mem_wr.
package riscv_pkg;

    typedef enum logic [2:0] {
        MASK_B  = 3'b000,
        MASK_H  = 3'b001,
        MASK_W  = 3'b010,
        MASK_BU = 3'b100,
        MASK_HU = 3'b101
    } mask_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } lsu_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic mask_legal(input logic [2:0] mask, input logic store);
        logic ok;
        case (mask)
            MASK_B, MASK_H, MASK_W: ok = 1'b1;
            MASK_BU, MASK_HU:       ok = !store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus: req/gnt address phase followed by an rvalid response
// phase that is used for both reads and writes.
interface lsu_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// misalign/illegal detection and load extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  mask,
    input  logic        store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;
    logic        sext;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be         = 4'b0000;
        wdata_lane = '0;
        misalign   = 1'b0;
        rdata_ext  = '0;
        illegal    = !mask_legal(mask, store);
        shifted    = rdata >> {addr_lo, 3'b000};
        sext       = !mask[2];

        case (mask[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                misalign   = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                misalign   = (addr_lo != 2'b00);
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = shifted;
            end
            default: ;
        endcase

        // Loads always fetch the whole word and pick the lane on return.
        if (!store) be = 4'b1111;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts a decoded memory op, runs one bus transaction,
// stalls the core meanwhile and formats load data for write-back.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mask_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        err_o,
    lsu_ctrl_if.master  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  mask_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] rdata_q;

    logic        in_idle, in_flight, access, both, accept, timeout;
    logic [2:0]  align_mask;
    logic        align_store;
    logic [1:0]  align_addr;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, rdata_ext;
    logic        misalign, illegal;

    assign in_idle   = (state_q == IDLE);
    assign in_flight = (state_q == REQ) || (state_q == RSP);
    assign access    = mem_rd_i | mem_wr_i;
    assign both      = mem_rd_i & mem_wr_i;
    assign accept    = in_idle & access & !both & !illegal & !misalign;
    assign timeout   = (TIMEOUT_CYCLES != 0) && in_flight && (cnt_q == CW'(TIMEOUT_CYCLES));

    // The decoder inputs are only meaningful in IDLE; afterwards the load
    // formatting must use the size and offset captured at accept.
    assign align_mask  = in_idle ? mask_i       : mask_q;
    assign align_store = in_idle ? mem_wr_i     : we_q;
    assign align_addr  = in_idle ? addr_i[1:0]  : addr_lo_q;

    lsu_align u_align (
        .mask       (align_mask),
        .store      (align_store),
        .addr_lo    (align_addr),
        .wdata      (wdata_i),
        .rdata      (bus.rdata),
        .be         (be_calc),
        .wdata_lane (wdata_calc),
        .misalign   (misalign),
        .illegal    (illegal),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (timeout) state_d = DONE;
                  else if (bus.gnt) state_d = RSP;
            RSP:  if (timeout || bus.rvalid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o    = accept | in_flight;
        bus.req    = (state_q == REQ) & !timeout;
        misalign_o = in_idle & access & !both & !illegal & misalign;
        err_o      = (in_idle & access & (both | illegal)) | ((state_q == DONE) & err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            mask_q    <= 3'b000;
            addr_lo_q <= 2'b00;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                we_q      <= mem_wr_i;
                mask_q    <= mask_i;
                addr_lo_q <= addr_i[1:0];
                addr_q    <= {addr_i[31:2], 2'b00};
                be_q      <= be_calc;
                wdata_q   <= wdata_calc;
                err_q     <= 1'b0;
            end

            if (in_flight && TIMEOUT_CYCLES != 0) cnt_q <= cnt_q + CW'(1);
            else                                  cnt_q <= '0;

            if (timeout) begin
                err_q <= 1'b1;
            end else if (state_q == RSP && bus.rvalid) begin
                if (bus.err)   err_q   <= 1'b1;
                else if (!we_q) rdata_q <= rdata_ext;
            end
        end
    end

    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads/stores, misalign and illegal rejects,
// bus error, withheld grant, timeout abort and mid-access reset.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, rd2 = 1'b0;
    logic [2:0]  mask = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, rdata2;
    logic        stall, misalign, err, stall2, misalign2, err2;

    int errors = 0;
    int checks = 0;

    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    lsu_ctrl_if bus ();
    lsu_ctrl_if bus2 ();

    always #5 clk = ~clk;

    lsu_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .mem_rd_i(rd), .mem_wr_i(wr), .mask_i(mask),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall),
        .misalign_o(misalign), .err_o(err), .bus(bus.master)
    );

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .mem_rd_i(rd2), .mem_wr_i(1'b0), .mask_i(mask),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata2), .stall_o(stall2),
        .misalign_o(misalign2), .err_o(err2), .bus(bus2.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full four-cycle access with grant in REQ and response one cycle later.
    task automatic run_access(input logic r, input logic w, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] resp, input logic rerr);
        rd = r; wr = w; mask = m; addr = a; wdata = d; bus.gnt = 1'b1;
        #1;
        check("accept_stall", 32'(stall), 32'd1);
        tick();
        rd = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFFF; wdata = '0;
        #1;
        check("req_high", 32'(bus.req), 32'd1);
        check("req_stall", 32'(stall), 32'd1);
        cap_we = bus.we; cap_addr = bus.addr; cap_be = bus.be; cap_wdata = bus.wdata;
        tick();
        bus.gnt = 1'b0;
        check("rsp_req_low", 32'(bus.req), 32'd0);
        check("rsp_stall", 32'(stall), 32'd1);
        bus.rvalid = 1'b1; bus.rdata = resp; bus.err = rerr;
        tick();
        bus.rvalid = 1'b0; bus.err = 1'b0;
        check("done_stall", 32'(stall), 32'd0);
        check("done_err", 32'(err), 32'(rerr));
        tick();
        check("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        logic seen;
        int   reqs;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        bus2.gnt = 1'b0; bus2.rvalid = 1'b0; bus2.rdata = '0; bus2.err = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'd0);

        // LW 0x100
        run_access(1'b1, 1'b0, MASK_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
        check("lw_addr", cap_addr, 32'h100);
        check("lw_be", 32'(cap_be), 32'hF);
        check("lw_we", 32'(cap_we), 32'd0);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);

        run_access(1'b1, 1'b0, MASK_B, 32'h103, 32'h0, 32'h80FF_0011, 1'b0);
        check("lb_addr", cap_addr, 32'h100);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, MASK_BU, 32'h103, 32'h0, 32'h80FF_0011, 1'b0);
        check("lbu_rdata", rdata, 32'h0000_0080);
        run_access(1'b1, 1'b0, MASK_H, 32'h102, 32'h0, 32'h80FF_0011, 1'b0);
        check("lh_rdata", rdata, 32'hFFFF_80FF);
        run_access(1'b1, 1'b0, MASK_HU, 32'h100, 32'h0, 32'h1234_F00F, 1'b0);
        check("lhu_rdata", rdata, 32'h0000_F00F);

        // Stores: lane replication and byte enables; rdata_o must hold.
        run_access(1'b0, 1'b1, MASK_B, 32'h201, 32'h0000_00A5, 32'h0, 1'b0);
        check("sb_we", 32'(cap_we), 32'd1);
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb_addr", cap_addr, 32'h200);
        run_access(1'b0, 1'b1, MASK_H, 32'h202, 32'h0000_1234, 32'h0, 1'b0);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'h1234_1234);
        check("st_rdata_hold", rdata, 32'h0000_F00F);

        // Bus error on a load: err in DONE, rdata unchanged.
        run_access(1'b1, 1'b0, MASK_W, 32'h104, 32'h0, 32'h5555_5555, 1'b1);
        check("buserr_rdata", rdata, 32'h0000_F00F);

        // Misaligned LW and SH rejected without a bus access.
        rd = 1'b1; mask = MASK_W; addr = 32'h102; #1;
        check("mis_lw_pulse", 32'(misalign), 32'd1);
        check("mis_lw_err", 32'(err), 32'd0);
        check("mis_lw_stall", 32'(stall), 32'd0);
        tick();
        rd = 1'b0; #1;
        check("mis_lw_noreq", 32'(bus.req), 32'd0);
        check("mis_lw_once", 32'(misalign), 32'd0);
        wr = 1'b1; mask = MASK_H; addr = 32'h101; #1;
        check("mis_sh_pulse", 32'(misalign), 32'd1);
        check("mis_sh_stall", 32'(stall), 32'd0);
        tick();
        wr = 1'b0; #1;
        check("mis_sh_noreq", 32'(bus.req), 32'd0);

        // Both requests, then a store with an unsigned mask.
        rd = 1'b1; wr = 1'b1; mask = MASK_W; addr = 32'h100; #1;
        check("both_err", 32'(err), 32'd1);
        check("both_stall", 32'(stall), 32'd0);
        check("both_mis", 32'(misalign), 32'd0);
        tick();
        rd = 1'b0; mask = MASK_BU; #1;
        check("ill_err", 32'(err), 32'd1);
        check("ill_stall", 32'(stall), 32'd0);
        tick();
        wr = 1'b0; #1;
        check("ill_noreq", 32'(bus.req), 32'd0);

        // Grant withheld for five cycles: bus fields must come from the latch.
        wr = 1'b1; mask = MASK_W; addr = 32'h300; wdata = 32'hCAFE_F00D; bus.gnt = 1'b0; #1;
        check("wait_accept", 32'(stall), 32'd1);
        tick();
        wr = 1'b0; addr = 32'h999; wdata = '0; #1;
        for (int i = 0; i < 5; i++) begin
            check("wait_req", 32'(bus.req), 32'd1);
            check("wait_addr", bus.addr, 32'h300);
            check("wait_be", 32'(bus.be), 32'hF);
            check("wait_wdata", bus.wdata, 32'hCAFE_F00D);
            check("wait_stall", 32'(stall), 32'd1);
            tick();
        end
        bus.gnt = 1'b1; #1;
        tick();
        bus.gnt = 1'b0; bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        check("wait_done_stall", 32'(stall), 32'd0);
        check("wait_done_err", 32'(err), 32'd0);
        tick();

        // Timeout instance: grant never arrives.
        rd2 = 1'b1; mask = MASK_W; addr = 32'h40; #1;
        check("to_accept", 32'(stall2), 32'd1);
        tick();
        rd2 = 1'b0; #1;
        seen = 1'b0; reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                if (err2) seen = 1'b1;
                else begin
                    if (bus2.req) reqs++;
                    tick();
                end
            end
        end
        check("to_err_seen", 32'(seen), 32'd1);
        check("to_req_cycles", 32'(reqs), 32'd4);
        check("to_done_stall", 32'(stall2), 32'd0);
        check("to_rdata", rdata2, 32'h0);
        tick();
        check("to_idle_err", 32'(err2), 32'd0);
        check("to_idle_stall", 32'(stall2), 32'd0);
        check("to_idle_req", 32'(bus2.req), 32'd0);

        // Reset while waiting in RSP, then a stale rvalid.
        rd = 1'b1; mask = MASK_W; addr = 32'h104; bus.gnt = 1'b1; #1;
        tick();
        rd = 1'b0;
        tick();
        bus.gnt = 1'b0; #1;
        check("rsp_before_rst", 32'(stall), 32'd1);
        rst_n = 1'b0; #1;
        check("rst_mid_req", 32'(bus.req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_rdata", rdata, 32'h0);
        #2 rst_n = 1'b1;
        bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777;
        tick();
        bus.rvalid = 1'b0; #1;
        check("stale_stall", 32'(stall), 32'd0);
        check("stale_err", 32'(err), 32'd0);
        check("stale_rdata", rdata, 32'h0);
        run_access(1'b1, 1'b0, MASK_W, 32'h108, 32'h0, 32'h1122_3344, 1'b0);
        check("post_rst_addr", cap_addr, 32'h108);
        check("post_rst_rdata", rdata, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
